paddsb_accum_seq: RTL and testbench

//   Sequencer for the 4-lane saturating nibble-add datapath. It performs a

---
 rtl/paddsb_accum_seq.sv | 116 +++++++++++
 tb/tb_paddsb_accum_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/paddsb_accum_seq.sv
// Burst reducer for the 4-lane saturating nibble adder: accumulates LEN operands
// into one 16-bit word with per-lane signed saturation and sticky overflow flags.
module paddsb_accum_seq #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [15:0]      init,
  input  logic             op_valid,
  input  logic [15:0]      op_data,
  output logic             op_ready,
  output logic             res_valid,
  output logic [15:0]      res_data,
  output logic [3:0]       res_sat,
  input  logic             res_ready,
  output logic             busy
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned LANE_W = 4;
  localparam int unsigned LANES  = DATA_W / LANE_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [LANES-1:0]   sat_q, sat_d;

  logic [DATA_W-1:0]  sum_c;
  logic [LANES-1:0]   ovf_c;

  // One lane: returns {overflow, saturated sum}; clamps toward the operands' sign.
  function automatic logic [LANE_W:0] lane_satadd(input logic [LANE_W-1:0] a,
                                                  input logic [LANE_W-1:0] b);
    logic [LANE_W-1:0] s;
    logic              ovf;
    s   = a + b;
    ovf = (a[LANE_W-1] == b[LANE_W-1]) && (s[LANE_W-1] != a[LANE_W-1]);
    if (ovf) begin
      return {1'b1, (a[LANE_W-1] ? 4'h8 : 4'h7)};
    end
    return {1'b0, s};
  endfunction

  always_comb begin
    sum_c = '0;
    ovf_c = '0;
    for (int i = 0; i < LANES; i++) begin
      {ovf_c[i], sum_c[i*LANE_W +: LANE_W]} =
        lane_satadd(acc_q[i*LANE_W +: LANE_W], op_data[i*LANE_W +: LANE_W]);
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    sat_d   = sat_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = init;
          rem_d   = len;
          sat_d   = '0;
          state_d = (len == '0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (op_valid) begin
          acc_d = sum_c;
          sat_d = sat_q | ovf_c;
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        // A start arriving with the result handshake is dropped on purpose.
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      sat_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      sat_q   <= sat_d;
    end
  end

  // Outputs are plain decodes of flops, so they clear with reset immediately.
  assign op_ready  = (state_q == S_ACCUM);
  assign res_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign res_data  = acc_q;
  assign res_sat   = sat_q;

endmodule

// File: tb/tb_paddsb_accum_seq.sv
// Self-checking bench for paddsb_accum_seq: directed scenarios plus random bursts
// compared against an integer-arithmetic saturating-sum model.
module tb_paddsb_accum_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic [15:0] init;
  logic        op_valid;
  logic [15:0] op_data;
  logic        op_ready;
  logic        res_valid;
  logic [15:0] res_data;
  logic [3:0]  res_sat;
  logic        res_ready;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [15:0] op_tab [256];

  paddsb_accum_seq #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .init      (init),
    .op_valid  (op_valid),
    .op_data   (op_data),
    .op_ready  (op_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_sat   (res_sat),
    .res_ready (res_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: each nibble as a signed integer, summed and clamped to [-8,7].
  task automatic model_add(input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] r, output logic [3:0] f);
    int sa, sb, sum;
    logic [3:0] na, nb;
    r = '0;
    f = '0;
    for (int i = 0; i < 4; i++) begin
      na  = a[i*4 +: 4];
      nb  = b[i*4 +: 4];
      sa  = (na >= 4'd8) ? int'(na) - 16 : int'(na);
      sb  = (nb >= 4'd8) ? int'(nb) - 16 : int'(nb);
      sum = sa + sb;
      if (sum > 7) begin
        sum  = 7;
        f[i] = 1'b1;
      end else if (sum < -8) begin
        sum  = -8;
        f[i] = 1'b1;
      end
      r[i*4 +: 4] = 4'(sum);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one burst with op_tab[0..n-1]; gap idle cycles before each op,
  // stall cycles of res_ready=0, and optional start pokes while busy.
  task automatic burst(input string tag, input logic [7:0] n, input logic [15:0] init_v,
                       input int gap, input int stall, input bit poke);
    logic [15:0] exp_acc, nxt;
    logic [3:0]  exp_sat, f;
    exp_acc = init_v;
    exp_sat = '0;
    start = 1'b1;
    len   = n;
    init  = init_v;
    step();
    start = 1'b0;
    len   = $urandom;
    init  = $urandom;
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".start_acc"}, 32'(res_data), 32'(init_v));
    for (int k = 0; k < int'(n); k++) begin
      for (int g = 0; g < gap; g++) begin
        op_valid = 1'b0;
        op_data  = $urandom;
        start    = poke;
        chk({tag, ".op_ready_gap"}, 32'(op_ready), 32'd1);
        step();
        start = 1'b0;
      end
      op_valid = 1'b1;
      op_data  = op_tab[k];
      chk({tag, ".op_ready"}, 32'(op_ready), 32'd1);
      chk({tag, ".res_valid_accum"}, 32'(res_valid), 32'd0);
      model_add(exp_acc, op_tab[k], nxt, f);
      exp_acc = nxt;
      exp_sat = exp_sat | f;
      step();
      op_valid = 1'b0;
      op_data  = $urandom;
      chk({tag, ".acc"}, 32'(res_data), 32'(exp_acc));
    end
    for (int s = 0; s < stall; s++) begin
      res_ready = 1'b0;
      start     = poke;
      chk({tag, ".res_valid_stall"}, 32'(res_valid), 32'd1);
      chk({tag, ".res_data_stall"}, 32'(res_data), 32'(exp_acc));
      step();
      start = 1'b0;
    end
    chk({tag, ".res_valid"}, 32'(res_valid), 32'd1);
    chk({tag, ".op_ready_done"}, 32'(op_ready), 32'd0);
    chk({tag, ".res_data"}, 32'(res_data), 32'(exp_acc));
    chk({tag, ".res_sat"}, 32'(res_sat), 32'(exp_sat));
    res_ready = 1'b1;
    start     = poke;
    step();
    res_ready = 1'b0;
    start     = 1'b0;
    chk({tag, ".busy_after"}, 32'(busy), 32'd0);
    chk({tag, ".res_valid_after"}, 32'(res_valid), 32'd0);
    step();
    chk({tag, ".idle_hold"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = '0;
    init      = '0;
    op_valid  = 1'b0;
    op_data   = '0;
    res_ready = 1'b0;
    #2;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.op_ready", 32'(op_ready), 32'd0);
    chk("rst.res_valid", 32'(res_valid), 32'd0);
    chk("rst.res_data", 32'(res_data), 32'd0);
    chk("rst.res_sat", 32'(res_sat), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Directed: plain add, then sticky saturation in both directions.
    op_tab[0] = 16'h1234;
    op_tab[1] = 16'h1111;
    burst("t1", 8'd2, 16'h0000, 0, 0, 1'b0);
    op_tab[0] = 16'h18F0;
    op_tab[1] = 16'hF000;
    burst("t2", 8'd2, 16'h7800, 0, 0, 1'b0);
    burst("t3", 8'd0, 16'hABCD, 0, 0, 1'b0);
    for (int k = 0; k < 3; k++) op_tab[k] = 16'($urandom);
    burst("t4", 8'd3, 16'($urandom), 2, 5, 1'b1);

    // Reset mid-burst, applied between clock edges.
    start = 1'b1;
    len   = 8'd3;
    init  = 16'h5555;
    step();
    start    = 1'b0;
    op_valid = 1'b1;
    op_data  = 16'h1111;
    step();
    op_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5.busy", 32'(busy), 32'd0);
    chk("t5.op_ready", 32'(op_ready), 32'd0);
    chk("t5.res_valid", 32'(res_valid), 32'd0);
    chk("t5.res_data", 32'(res_data), 32'd0);
    chk("t5.res_sat", 32'(res_sat), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    op_tab[0] = 16'h0001;
    burst("t5b", 8'd1, 16'h0000, 0, 0, 1'b0);

    // Start coincident with result handshake is dropped, next start accepted.
    op_tab[0] = 16'h7777;
    burst("t6", 8'd1, 16'h0101, 0, 2, 1'b1);
    op_tab[0] = 16'h8888;
    burst("t6b", 8'd1, 16'h8181, 0, 0, 1'b0);

    for (int r = 0; r < 25; r++) begin
      int n;
      n = int'($urandom_range(1, 6));
      for (int k = 0; k < n; k++) op_tab[k] = 16'($urandom);
      burst("rnd", 8'(n), 16'($urandom), int'($urandom_range(0, 2)),
            int'($urandom_range(0, 4)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
